// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle adder summing DIGIT bits per clock with start/busy/done handshake
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [IW-1:0]    w_base;
    logic [DIGIT-1:0] w_a_slice;
    logic [DIGIT-1:0] w_b_slice;
    logic [DIGIT-1:0] w_sum_slice;
    logic             w_carry_out;

    // Slice index: count*DIGIT never exceeds WIDTH-DIGIT, so IW bits always suffice.
    assign w_base    = IW'(r_count) * IW'(DIGIT);
    assign w_last    = (r_count == CW'(N - 1));
    assign w_a_slice = r_a[w_base +: DIGIT];
    assign w_b_slice = r_b[w_base +: DIGIT];
    assign {w_carry_out, w_sum_slice} = {1'b0, w_a_slice} + {1'b0, w_b_slice}
                                        + (DIGIT + 1)'(r_carry);

    assign o_s    = r_s;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

    // State register; reset aborts any add in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; FIN accepts START like IDLE for gapless back-to-back adds.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                o_done = 1'b1;
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture and slice-by-slice accumulation; flags latch on the final slice.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_cin;
            r_count <= '0;
        end else if (w_step) begin
            r_s[w_base +: DIGIT] <= w_sum_slice;
            r_carry              <= w_carry_out;
            r_count              <= r_count + 1'b1;
            if (w_last) begin
                r_cout <= w_carry_out;
                // a^b^s at the MSB recovers the carry into the MSB.
                r_ovf  <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum_slice[DIGIT-1] ^ w_carry_out;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (16/4, 4/1 and 4/4 instances)
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        m_start, m_cin, m_busy, m_done, m_cout, m_ovf;
    logic [15:0] m_a, m_b, m_s;

    logic        p_start, p_cin, p_busy, p_done, p_cout, p_ovf;
    logic [3:0]  p_a, p_b, p_s;

    logic        q_start, q_cin, q_busy, q_done, q_cout, q_ovf;
    logic [3:0]  q_a, q_b, q_s;

    int checks   = 0;
    int failures = 0;

    logic [17:0] sb[$];
    logic [5:0]  sb4[$];

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_main (
        .i_clk(clk), .i_rst(rst), .i_start(m_start), .i_a(m_a), .i_b(m_b), .i_cin(m_cin),
        .o_busy(m_busy), .o_done(m_done), .o_s(m_s), .o_cout(m_cout), .o_ovf(m_ovf)
    );

    serial_adder #(.WIDTH(4), .DIGIT(1)) u_bit (
        .i_clk(clk), .i_rst(rst), .i_start(p_start), .i_a(p_a), .i_b(p_b), .i_cin(p_cin),
        .o_busy(p_busy), .o_done(p_done), .o_s(p_s), .o_cout(p_cout), .o_ovf(p_ovf)
    );

    serial_adder #(.WIDTH(4), .DIGIT(4)) u_one (
        .i_clk(clk), .i_rst(rst), .i_start(q_start), .i_a(q_a), .i_b(q_b), .i_cin(q_cin),
        .o_busy(q_busy), .o_done(q_done), .o_s(q_s), .o_cout(q_cout), .o_ovf(q_ovf)
    );

    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
        logic [16:0] t;
        logic        v;
        t = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        v = (a[15] == b[15]) && (t[15] != a[15]);
        return {v, t[16], t[15:0]};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b,
                                          input logic cin);
        logic [4:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        v = (a[3] == b[3]) && (t[3] != a[3]);
        return {v, t[4], t[3:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic cin);
        m_a     = a;
        m_b     = b;
        m_cin   = cin;
        m_start = 1'b1;
        sb.push_back(model16(a, b, cin));
    endtask

    task automatic wait_done(input int lat0, output int lat, output int busy_n);
        lat    = lat0;
        busy_n = 0;
        while (m_done !== 1'b1 && lat < 40) begin
            if (m_busy === 1'b1) busy_n++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({m_busy, m_done, m_s, m_cout, m_ovf} !== 20'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b s=%h cout=%b ovf=%b exp all zero",
                     m_busy, m_done, m_s, m_cout, m_ovf);
        end
    endtask

    task automatic test_basic();
        int lat, bn;
        logic [17:0] e;
        start16(16'h1234, 16'h4321, 1'b0);
        tick();
        m_start = 1'b0;
        wait_done(1, lat, bn);
        e = sb.pop_front();
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        checks++;
        if (bn !== 4) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=4", bn); end
        checks++;
        if ({m_ovf, m_cout, m_s} !== e) begin
            failures++;
            $display("FAIL basic_result got=%h exp=%h", {m_ovf, m_cout, m_s}, e);
        end
        tick();
        checks++;
        if (m_done !== 1'b0 || m_s !== e[15:0]) begin
            failures++;
            $display("FAIL basic_pulse_hold got done=%b s=%h exp done=0 s=%h", m_done, m_s, e[15:0]);
        end
    endtask

    task automatic test_carry_ovf();
        logic [15:0] va [2];
        logic [15:0] vb [2];
        int lat, bn;
        logic [17:0] e;
        va = '{16'hFFFF, 16'h7FFF};
        vb = '{16'h0001, 16'h0001};
        for (int k = 0; k < 2; k++) begin
            start16(va[k], vb[k], 1'b0);
            tick();
            m_start = 1'b0;
            wait_done(1, lat, bn);
            e = sb.pop_front();
            checks++;
            if (lat !== 5 || {m_ovf, m_cout, m_s} !== e) begin
                failures++;
                $display("FAIL carry_ovf_%0d got lat=%0d res=%h exp lat=5 res=%h",
                         k, lat, {m_ovf, m_cout, m_s}, e);
            end
            tick();
        end
    endtask

    task automatic test_ripple_ignore();
        int lat, bn, nd;
        logic [17:0] e;
        start16(16'h00FF, 16'h0000, 1'b1);
        tick();
        m_start = 1'b0;
        m_a     = 16'hAAAA;
        m_b     = 16'h5555;
        m_cin   = 1'b1;
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        m_a     = 16'hFFFF;
        wait_done(2, lat, bn);
        e = sb.pop_front();
        checks++;
        if (lat !== 5 || {m_ovf, m_cout, m_s} !== e) begin
            failures++;
            $display("FAIL ripple_result got lat=%0d res=%h exp lat=5 res=%h",
                     lat, {m_ovf, m_cout, m_s}, e);
        end
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_done === 1'b1 || m_busy === 1'b1) nd++;
        end
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL ignore_start_extra got=%0d exp=0", nd); end
    endtask

    task automatic test_reset_mid();
        int lat, bn, nd;
        logic [17:0] e;
        start16(16'hF00F, 16'h0FF1, 1'b0);
        tick();
        m_start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({m_busy, m_done, m_s, m_cout, m_ovf} !== 20'd0) begin
            failures++;
            $display("FAIL reset_mid_clear got busy=%b done=%b s=%h cout=%b ovf=%b exp all zero",
                     m_busy, m_done, m_s, m_cout, m_ovf);
        end
        sb.delete();
        tick();
        rst = 1'b0;
        nd  = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m_done === 1'b1 || m_busy === 1'b1) nd++;
        end
        checks++;
        if (nd !== 0) begin failures++; $display("FAIL reset_mid_no_done got=%0d exp=0", nd); end
        start16(16'h0F0F, 16'h0101, 1'b1);
        tick();
        m_start = 1'b0;
        wait_done(1, lat, bn);
        e = sb.pop_front();
        checks++;
        if (lat !== 5 || {m_ovf, m_cout, m_s} !== e) begin
            failures++;
            $display("FAIL reset_mid_recover got lat=%0d res=%h exp lat=5 res=%h",
                     lat, {m_ovf, m_cout, m_s}, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vc [4];
        int lat, bn;
        logic [17:0] e;
        va = '{16'hABCD, 16'h8000, 16'h7FFF, 16'h0000};
        vb = '{16'h1234, 16'h8000, 16'h7FFF, 16'h0000};
        vc = '{1'b1, 1'b0, 1'b1, 1'b0};
        start16(va[0], vb[0], vc[0]);
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) start16(va[k], vb[k], vc[k]);
            else m_start = 1'b0;
            wait_done(1, lat, bn);
            e = sb.pop_front();
            checks++;
            if (lat !== 5 || {m_ovf, m_cout, m_s} !== e) begin
                failures++;
                $display("FAIL b2b_%0d got lat=%0d res=%h exp lat=5 res=%h",
                         k - 1, lat, {m_ovf, m_cout, m_s}, e);
            end
            tick();
            checks++;
            if (m_busy !== (k < 4)) begin
                failures++;
                $display("FAIL b2b_gap_%0d got busy=%b exp=%b", k, m_busy, (k < 4));
            end
        end
    endtask

    task automatic test_exhaustive_w4();
        int lat, explat;
        logic [5:0] e, got;
        logic       dn;
        for (int k = 0; k < 2; k++) begin
            explat = (k == 0) ? 5 : 2;
            for (int v = 0; v < 512; v++) begin
                logic [8:0] vv;
                vv = v[8:0];
                if (k == 0) begin
                    p_a = vv[3:0]; p_b = vv[7:4]; p_cin = vv[8]; p_start = 1'b1;
                end else begin
                    q_a = vv[3:0]; q_b = vv[7:4]; q_cin = vv[8]; q_start = 1'b1;
                end
                sb4.push_back(model4(vv[3:0], vv[7:4], vv[8]));
                tick();
                p_start = 1'b0;
                q_start = 1'b0;
                lat = 1;
                dn  = (k == 0) ? p_done : q_done;
                while (dn !== 1'b1 && lat < 20) begin
                    tick();
                    lat++;
                    dn = (k == 0) ? p_done : q_done;
                end
                e   = sb4.pop_front();
                got = (k == 0) ? {p_ovf, p_cout, p_s} : {q_ovf, q_cout, q_s};
                checks++;
                if (lat !== explat || got !== e) begin
                    failures++;
                    $display("FAIL exh_digit%0d a=%h b=%h cin=%b got lat=%0d res=%h exp lat=%0d res=%h",
                             (k == 0) ? 1 : 4, vv[3:0], vv[7:4], vv[8], lat, got, explat, e);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst     = 1'b1;
        m_start = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0;
        p_start = 1'b0; p_a = '0; p_b = '0; p_cin = 1'b0;
        q_start = 1'b0; q_a = '0; q_b = '0; q_cin = 1'b0;
        tick();
        tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_basic();
        test_carry_ovf();
        test_ripple_ignore();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive_w4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
